// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding one 8E1 UART transmitter.
// Frame is start, 8 data bits MSB first, even parity, stop.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  output logic [3:0]  gnt,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CW = (CLKS_PER_BIT > 1) ?
                      $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      byte_q;
  logic [1:0]      last_grant;

  logic            hit;
  logic [1:0]      sel;
  logic [1:0]      idx;
  logic            bit_end;
  logic            arb;

  assign bit_end = (cnt == LAST);

  // Arbitrate on a free IDLE cycle, or on the last STOP cycle so the
  // grant pulse lands in the single IDLE cycle between frames.
  assign arb = (state == IDLE && gnt == 4'b0000) ||
               (state == STOP && bit_end);

  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_q     <= '0;
      last_grant <= 2'd3;
      gnt        <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      if (state != IDLE)
        cnt <= bit_end ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (gnt != 4'b0000) begin
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= byte_q[7];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state   <= PARITY;
              tx      <= ^byte_q;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= byte_q[3'd6 - bit_idx];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          done <= (cnt == PRE);
          if (bit_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (arb && hit) begin
        gnt        <= 4'b0001 << sel;
        byte_q     <= data_in[{sel, 3'b000} +: 8];
        last_grant <= sel;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-level reference model plus
// directed literal checks and randomized request traffic.
module tb_uart_tx_arbiter;

  localparam int C = 4;
  localparam int FL = 11 * C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic        tx;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_arbiter #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data_in (data_in),
    .gnt     (gnt),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h",
               nm, $time, a, e);
    end
  endtask

  // Model: a frame is known by its grant cycle, byte and requester.
  int         cyc  = 0;
  int         mg   = 0;
  bit         mact = 1'b0;
  logic [7:0] mb   = '0;
  int         ml   = 3;

  always @(posedge clk) begin
    int f;
    cyc++;
    if (!rst_n) begin
      mact = 1'b0;
      ml   = 3;
    end else if (!mact || (cyc - 1 - mg) >= FL) begin
      f = -1;
      for (int k = 1; k <= 4; k++)
        if (f < 0 && req[(ml + k) % 4]) f = (ml + k) % 4;
      if (f >= 0) begin
        ml   = f;
        mact = 1'b1;
        mg   = cyc;
        mb   = data_in[8*f +: 8];
      end
    end
  end

  bit         chk_en = 1'b0;
  logic [6:0] ex;
  int         o;
  int         b;
  logic       t;

  always @(negedge clk) begin
    if (chk_en) begin
      #1;
      ex = 7'b0000100;
      o  = cyc - mg;
      if (rst_n && mact && o >= 0 && o <= FL) begin
        if (o == 0) begin
          ex = {4'(1 << ml), 3'b100};
        end else begin
          b = (o - 1) / C;
          if (b == 0)      t = 1'b0;
          else if (b <= 8) t = mb[8 - b];
          else if (b == 9) t = ^mb;
          else             t = 1'b1;
          ex = {4'b0000, t, 1'b1, o == FL};
        end
      end
      chk("outputs", {25'b0, gnt, tx, busy, done}, {25'b0, ex});
    end
  end

  task automatic wait_gnt(output logic [3:0] g);
    g = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      #2;
      if (gnt != 4'b0000) begin
        g = gnt;
        break;
      end
    end
    chk("gnt_seen", 32'(g != 4'b0000), 1);
  endtask

  task automatic frame(input int i,
                       input logic [7:0] bt,
                       input logic [10:0] lit);
    logic [3:0] g;
    @(negedge clk);
    req[i] = 1'b1;
    data_in[8*i +: 8] = bt;
    wait_gnt(g);
    chk("frame_gnt", 32'(g), 32'(1 << i));
    req[i] = 1'b0;
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      #2;
      if (k % C == 2 && k <= FL - 2)
        chk("frame_bit", 32'(tx), 32'(lit[10 - (k - 2) / C]));
      if (k == FL - 1) chk("done_early", 32'(done), 0);
      if (k == FL)     chk("done_last", 32'(done), 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] gs [5];
    int         ts [5];
    int         ng;
    int         seen;

    rst_n   = 1'b0;
    req     = '0;
    data_in = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("reset_out", {25'b0, gnt, tx, busy, done}, 32'h04);

    frame(0, 8'hA5, 11'b01010010101);
    frame(1, 8'h07, 11'b00000011111);
    frame(2, 8'h00, 11'b00000000001);

    // All four requesting from reset.
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'hF;
    data_in = 32'h1122_3344;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ng = 0;
    for (int n = 0; n < 5 * (FL + 1) + 20 && ng < 5; n++) begin
      @(negedge clk);
      #2;
      if (gnt != 4'b0000) begin
        gs[ng] = gnt;
        ts[ng] = cyc;
        ng++;
      end
    end
    req = '0;
    chk("rr_count", 32'(ng), 5);
    for (int k = 0; k < ng; k++) begin
      chk("rr_order", 32'(gs[k]), 32'(1 << (k % 4)));
      if (k > 0) chk("rr_space", 32'(ts[k] - ts[k-1]), FL + 1);
    end
    repeat (FL + 2) @(negedge clk);

    // Pending 1010 after last_grant=1; mid-frame data change.
    frame(1, 8'h3C, 11'b00011110001);
    @(negedge clk);
    req = 4'b1010;
    data_in[31:24] = 8'h5A;
    data_in[15:8]  = 8'hC3;
    wait_gnt(g);
    chk("rr_1010_first", 32'(g), 32'h8);
    req[3] = 1'b0;
    repeat (10) @(negedge clk);
    data_in[31:24] = 8'hFF;
    wait_gnt(g);
    chk("rr_1010_next", 32'(g), 32'h2);
    req[1] = 1'b0;
    repeat (FL + 2) @(negedge clk);

    // Reset in the middle of DATA.
    @(negedge clk);
    req[0] = 1'b1;
    data_in[7:0] = 8'hA5;
    wait_gnt(g);
    req[0] = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame(2, 8'h00, 11'b00000000001);

    // One-cycle request while busy is dropped.
    @(negedge clk);
    req[0] = 1'b1;
    data_in[7:0] = 8'h81;
    wait_gnt(g);
    req[0] = 1'b0;
    repeat (20) @(negedge clk);
    req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    seen = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      #2;
      if (gnt[2]) seen++;
    end
    chk("no_gnt2", 32'(seen), 0);
    chk("idle_after", 32'(busy), 0);

    // Random traffic; requesters drop req when granted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (gnt[i])
          req[i] = 1'b0;
        else if (!req[i] && $urandom_range(15) == 0)
          req[i] = 1'b1;
        else if (req[i] && $urandom_range(199) == 0)
          req[i] = 1'b0;
      end
      data_in = $urandom;
    end
    req = '0;
    repeat (FL + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] high means requester i has a byte to send.
REQ-005 The block SHALL have port data_in, input, 32 bits: requester i's byte on data_in[8*i+7:8*i].
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot, one-cycle pulse marking the cycle requester i's byte is accepted.
REQ-007 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame is on the line.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-010 The block SHALL implement states IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE with req nonzero, the block SHALL grant the first requester with req high, searching round-robin from last_grant+1 modulo 4.
REQ-012 In the grant cycle the block SHALL pulse gnt[i], latch the selected byte, update last_grant to i and move to START.
REQ-013 In IDLE with req zero, the block SHALL hold state, tx=1, busy=0 and gnt=0.
REQ-014 START SHALL drive tx=0 for CLKS_PER_BIT cycles, starting the cycle after the grant.
REQ-015 DATA SHALL send the 8 latched bits MSB first (bit 7 first), each held CLKS_PER_BIT cycles, using a 3-bit bit index and a baud counter of width ceil(log2(CLKS_PER_BIT)).
REQ-016 PARITY SHALL drive the XOR of the 8 latched data bits (even parity) for CLKS_PER_BIT cycles.
REQ-017 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-018 The block SHALL assert done during the last cycle of STOP, then enter IDLE.
REQ-019 The complete frame SHALL last exactly 11*CLKS_PER_BIT cycles.
REQ-020 busy SHALL be high in START, DATA, PARITY and STOP, and low in IDLE.
REQ-021 The block SHALL spend at least one cycle in IDLE between frames; back-to-back grants are spaced 11*CLKS_PER_BIT+1 cycles apart.
REQ-022 Changes on req or data_in while busy SHALL NOT affect the frame in flight.
REQ-023 Requests made while busy SHALL be held pending and arbitrated in the next IDLE cycle; a requester keeps req high until it sees its gnt.
REQ-024 A req deasserted before its grant SHALL be dropped, with no gnt issued.
REQ-025 gnt SHALL be asserted only in IDLE and SHALL NOT have more than one bit high in the same cycle.
REQ-026 The baud counter SHALL wrap to 0 at CLKS_PER_BIT-1 on each bit boundary.
REQ-027 The bit index SHALL wrap from 7 to 0 on the DATA-to-PARITY transition.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While rst_n=0, the block SHALL set state=IDLE, tx=1, busy=0, done=0, gnt=0, last_grant=3, counters=0 and the latched byte=0.
REQ-030 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronous) and abort the frame with no done pulse.
REQ-031 After rst_n deasserts, the first arbitration SHALL give requester 0 the highest priority.

Verification (CLKS_PER_BIT=4)
REQ-032 Single request: req=4'b0001, data_in[7:0]=8'hA5 -> gnt=0001 pulse; tx 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, parity 0, stop 1; done 44 cycles after the grant.
REQ-033 Parity: data 8'h07 -> parity bit 1; data 8'h00 -> parity bit 0.
REQ-034 All four requesting continuously from reset -> gnt order 0,1,2,3,0, grants spaced 45 cycles apart.
REQ-035 req=4'b1010 with last_grant=1 -> gnt[3] first, gnt[1] next; changing data_in[31:24] mid-frame leaves the serial bits unchanged.
REQ-036 rst_n pulled low during DATA -> tx=1 in the same cycle, busy=0, no done; a new request afterward sends a full correct frame.
REQ-037 req[2] pulsed for 1 cycle while busy and then dropped -> gnt[2] is never asserted and the block stays in IDLE.
